fwd_hazard_unit: RTL and testbench

// Control-side counterpart of the 32-bit 3:1 operand muxes in the 5-stage pipeline datapath.

---
 rtl/fwd_hazard_unit.sv | 110 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall control for the 5-stage pipeline.
// Shadows destination registers through EX, MEM and WB.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              bubble;

  logic mem_hit_a;
  logic mem_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;
  logic ex_load;

  assign mem_hit_a = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
  assign mem_hit_b = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt);
  assign wb_hit_a  = wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs);
  assign wb_hit_b  = wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt);

  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    fwd_a_sel = 2'b00;
    priority case (1'b1)
      mem_hit_a: fwd_a_sel = 2'b10;
      wb_hit_a:  fwd_a_sel = 2'b01;
      default:   fwd_a_sel = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    priority case (1'b1)
      mem_hit_b: fwd_b_sel = 2'b10;
      wb_hit_b:  fwd_b_sel = 2'b01;
      default:   fwd_b_sel = 2'b00;
    endcase
  end

  assign ex_load = ex_memread && (ex_rd != '0);

  assign stall = id_valid && !flush && ex_load &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign bubble     = stall || flush || !id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (bubble) begin
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: pipeline-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic       flush = 1'b0;

  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic        pc_write;
  logic        ifid_write;
  logic [15:0] stall_cnt;

  logic [1:0] s_fa;
  logic [1:0] s_fb;
  logic       s_st;
  logic       s_pw;
  logic       s_iw;
  logic [3:0] s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall(s_st),
    .pc_write(s_pw), .ifid_write(s_iw), .stall_cnt(s_cnt)
  );

  // model: instructions in flight, index 0=EX, 1=MEM, 2=WB
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  ins_t pipe [3];
  int   m_stalls;

  function automatic logic [1:0] m_sel(input logic [4:0] r);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].wr && pipe[s].rd != 0 && pipe[s].rd == r)
        return (s == 1) ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    if (!id_valid || flush) return 1'b0;
    if (!pipe[0].ld || pipe[0].rd == 0) return 1'b0;
    return pipe[0].rd == id_rs || (id_uses_rt && pipe[0].rd == id_rt);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_stalls = 0;
    end else begin
      logic st;
      st = m_stall();
      if (st) m_stalls = m_stalls + 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st || flush || !id_valid) pipe[0] = '0;
      else pipe[0] = '{id_rs, id_rt, id_rd, id_regwrite, id_memread};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic st;
    int c16;
    int c4;
    st  = m_stall();
    c16 = (m_stalls > 65535) ? 65535 : m_stalls;
    c4  = (m_stalls > 15) ? 15 : m_stalls;
    chk("m_fwd_a", fwd_a_sel, m_sel(pipe[0].rs));
    chk("m_fwd_b", fwd_b_sel, m_sel(pipe[0].rt));
    chk("m_stall", stall, st);
    chk("m_pc_write", pc_write, !st);
    chk("m_ifid_write", ifid_write, !st);
    chk("m_cnt16", stall_cnt, c16);
    chk("m_cnt4", s_cnt, c4);
  end

  task automatic set_id(input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ut,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fl);
    id_valid = v;
    id_rs = rs;
    id_rt = rt;
    id_uses_rt = ut;
    id_rd = rd;
    id_regwrite = rw;
    id_memread = mr;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic [4:0] rd,
                     input logic rw, input logic mr);
    set_id(1'b1, rs, rt, ut, rd, rw, mr, 1'b0);
    tick();
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc_write", pc_write, 1);
    nop();

    // back-to-back ALU, then with one gap
    ins(5'd1, 5'd2, 1, 5'd3, 1, 0);
    ins(5'd3, 5'd4, 1, 5'd6, 1, 0);
    chk("b2b_fwd_a", fwd_a_sel, 2);
    chk("b2b_fwd_b", fwd_b_sel, 0);
    ins(5'd1, 5'd2, 1, 5'd8, 1, 0);
    nop();
    ins(5'd8, 5'd1, 1, 5'd9, 1, 0);
    chk("gap_fwd_a", fwd_a_sel, 1);

    // double hazard on rt
    ins(5'd1, 5'd2, 1, 5'd5, 1, 0);
    ins(5'd1, 5'd2, 1, 5'd5, 1, 0);
    ins(5'd1, 5'd5, 1, 5'd10, 1, 0);
    chk("dbl_fwd_b", fwd_b_sel, 2);
    nop();

    // load-use
    ins(5'd1, 5'd0, 0, 5'd7, 1, 1);
    set_id(1, 5'd7, 5'd2, 1, 5'd11, 1, 0, 0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    tick();
    chk("lu_stall_gone", stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    tick();
    chk("lu_fwd_a", fwd_a_sel, 1);
    nop();

    // flush beats stall
    ins(5'd1, 5'd0, 0, 5'd9, 1, 1);
    set_id(1, 5'd9, 5'd2, 1, 5'd12, 1, 0, 1);
    #1;
    chk("fl_stall", stall, 0);
    chk("fl_pc_write", pc_write, 1);
    nop();
    chk("fl_fwd_a", fwd_a_sel, 0);
    chk("fl_cnt", stall_cnt, 1);

    // reset asserted mid-stall
    ins(5'd1, 5'd0, 0, 5'd7, 1, 1);
    set_id(1, 5'd7, 5'd7, 1, 5'd13, 1, 0, 0);
    #1;
    chk("mr_pre_stall", stall, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_stall", stall, 0);
    chk("mr_pc_write", pc_write, 1);
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_fwd_a", fwd_a_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    ins(5'd7, 5'd7, 1, 5'd14, 1, 0);
    chk("mr_post_fwd_a", fwd_a_sel, 0);
    chk("mr_post_fwd_b", fwd_b_sel, 0);

    // register 0 never forwarded or stalled on
    ins(5'd1, 5'd2, 1, 5'd0, 1, 0);
    ins(5'd0, 5'd0, 1, 5'd15, 1, 0);
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);
    ins(5'd1, 5'd0, 0, 5'd0, 1, 1);
    set_id(1, 5'd0, 5'd0, 1, 5'd16, 1, 0, 0);
    #1;
    chk("r0_stall", stall, 0);
    nop();

    // saturation: a self-dependent load stalls every second edge
    set_id(1, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0);
    repeat (38) tick();
    chk("sat_cnt16", stall_cnt, 19);
    chk("sat_cnt4", s_cnt, 15);
    nop();
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
